event_frame_arbiter: RTL and testbench

Parametrised successor to the single-cycle sensor/stopwatch event packer. It gives each event source its own holding slot, so simultaneous or back-to-back events are never lost, and it arbitrates between the slots in either fixed-priority or round-robin order. Each frame is emitted as {tag, payload} to the downstream UART/frame sender over a valid/ready handshake. The block sits between the function blocks (stopwatch, watch, SR04, DHT11) and the transmit path.

---
 rtl/event_frame_arbiter_if.sv | 29 ++
 rtl/event_frame_arbiter.sv | 114 +++++++++++
 tb/tb_event_frame_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/event_frame_arbiter_if.sv
// Bus between the event producers, the frame arbiter and the downstream sender.
// Handshake: a frame moves on every rising clk edge where o_valid && i_ready.
// Once o_valid is high, o_valid and o_data stay unchanged until that edge.
interface event_frame_arbiter_if #(
  parameter int NUM_CH    = 7,
  parameter int TAG_W     = 4,
  parameter int PAYLOAD_W = 60
);
  logic [NUM_CH-1:0]           i_trig;
  logic [NUM_CH*PAYLOAD_W-1:0] i_payload;
  logic                        i_ready;
  logic                        i_ovf_clr;
  logic                        o_valid;
  logic [TAG_W+PAYLOAD_W-1:0]  o_data;
  logic [NUM_CH-1:0]           o_overflow;
  logic                        o_busy;

  // Producer/consumer side: drives events and ready, observes frames.
  modport master (
    output i_trig, i_payload, i_ready, i_ovf_clr,
    input  o_valid, o_data, o_overflow, o_busy
  );

  // Arbiter side.
  modport slave (
    input  i_trig, i_payload, i_ready, i_ovf_clr,
    output o_valid, o_data, o_overflow, o_busy
  );
endinterface

// File: rtl/event_frame_arbiter.sv
// Per-channel event holding slots with a single registered output frame.
// Pending slots are granted in fixed-priority or round-robin order and sent
// as {channel+1, payload}. Events hitting a busy slot are dropped and flagged.
module event_frame_arbiter #(
  parameter int NUM_CH    = 7,
  parameter int TAG_W     = 4,
  parameter int PAYLOAD_W = 60,
  parameter int ARB_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  event_frame_arbiter_if.slave bus
);
  localparam int LG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW   = TAG_W + PAYLOAD_W;

  logic [PAYLOAD_W-1:0] slot_q [NUM_CH];
  logic [PAYLOAD_W-1:0] slot_d [NUM_CH];
  logic [NUM_CH-1:0]    pend_q, pend_d;
  logic [NUM_CH-1:0]    ovf_q, ovf_d;
  logic                 valid_q, valid_d;
  logic [DW-1:0]        data_q, data_d;
  logic [LG_W-1:0]      last_q, last_d;

  logic                 found;
  logic [LG_W-1:0]      gnt;
  logic [LG_W:0]        rr_idx;
  logic                 can_load;
  logic                 grant;
  logic [NUM_CH-1:0]    ovf_set;

  // Pick the winning pending slot; round robin starts just after the last grant.
  always_comb begin
    found  = 1'b0;
    gnt    = '0;
    rr_idx = '0;
    if (ARB_MODE == 0) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (pend_q[c]) begin
          found = 1'b1;
          gnt   = LG_W'(c);
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        rr_idx = {1'b0, last_q} + (LG_W+1)'(k + 1);
        if (rr_idx >= (LG_W+1)'(NUM_CH)) rr_idx = rr_idx - (LG_W+1)'(NUM_CH);
        if (!found && pend_q[rr_idx[LG_W-1:0]]) begin
          found = 1'b1;
          gnt   = rr_idx[LG_W-1:0];
        end
      end
    end
  end

  // Next state for slots, output frame, last grant and sticky overflow.
  always_comb begin
    can_load = !valid_q || bus.i_ready;
    grant    = can_load && found;
    pend_d   = pend_q;
    slot_d   = slot_q;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    ovf_set  = '0;

    if (grant) begin
      pend_d[gnt] = 1'b0;
      valid_d     = 1'b1;
      data_d      = {TAG_W'(gnt) + TAG_W'(1), slot_q[gnt]};
      last_d      = gnt;
    end else if (can_load) begin
      valid_d = 1'b0;
    end

    // A retrigger on the slot being granted refills it rather than overflowing.
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.i_trig[c]) begin
        if (!pend_q[c] || (grant && (gnt == LG_W'(c)))) begin
          slot_d[c] = bus.i_payload[c*PAYLOAD_W +: PAYLOAD_W];
          pend_d[c] = 1'b1;
        end else begin
          ovf_set[c] = 1'b1;
        end
      end
    end

    ovf_d = (bus.i_ovf_clr ? '0 : ovf_q) | ovf_set;
  end

  // State registers; reset discards every slot and the output frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) slot_q[c] <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= LG_W'(NUM_CH - 1);
    end else begin
      for (int c = 0; c < NUM_CH; c++) slot_q[c] <= slot_d[c];
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_busy     = (|pend_q) | valid_q;
endmodule

// File: tb/tb_event_frame_arbiter.sv
// Bench for event_frame_arbiter: a fixed-priority and a round-robin instance,
// directed stimulus, expected frames queued at stimulus time and popped by
// per-instance monitors on every accepted frame.
module tb_event_frame_arbiter;
  localparam int NUM_CH = 7;
  localparam int TAG_W  = 4;
  localparam int PW     = 60;
  localparam int DW     = TAG_W + PW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Clock / reset
  always #5 clk = ~clk;

  event_frame_arbiter_if #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) if0 ();
  event_frame_arbiter_if #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) if1 ();

  event_frame_arbiter #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .PAYLOAD_W(PW), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  event_frame_arbiter #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .PAYLOAD_W(PW), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  // Scoreboard
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] rr_exp [9] = '{
    {4'd1, 60'h101}, {4'd3, 60'h101}, {4'd1, 60'h102}, {4'd3, 60'h103},
    {4'd1, 60'h104}, {4'd3, 60'h105}, {4'd1, 60'h106}, {4'd3, 60'h107},
    {4'd1, 60'h108}
  };

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every accepted frame must match the head of its queue
  always @(negedge clk) begin
    if (rst && if0.o_valid && if0.i_ready) begin
      if (exp_q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut0_unexpected_frame: got %h expected none", if0.o_data);
      end else begin
        check("dut0_frame", if0.o_data, exp_q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst && if1.o_valid && if1.i_ready) begin
      if (exp_q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut1_unexpected_frame: got %h expected none", if1.o_data);
      end else begin
        check("dut1_frame", if1.o_data, exp_q1.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pl0(input int c, input logic [PW-1:0] v);
    if0.i_payload[c*PW +: PW] = v;
  endtask

  task automatic set_pl1(input int c, input logic [PW-1:0] v);
    if1.i_payload[c*PW +: PW] = v;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    if0.i_trig = '0; if0.i_payload = '0; if0.i_ready = 1'b1; if0.i_ovf_clr = 1'b0;
    if1.i_trig = '0; if1.i_payload = '0; if1.i_ready = 1'b1; if1.i_ovf_clr = 1'b0;

    // Reset state
    tick();
    check("rst_valid0", DW'(if0.o_valid), '0);
    check("rst_data0", if0.o_data, '0);
    check("rst_ovf0", DW'(if0.o_overflow), '0);
    check("rst_busy0", DW'(if0.o_busy), '0);
    check("rst_valid1", DW'(if1.o_valid), '0);
    #2 rst = 1'b1;
    tick();

    // 1: single event, two-edge latency, one-cycle frame
    set_pl0(1, 60'h123);
    if0.i_trig = 7'b0000010;
    exp_q0.push_back({4'd2, 60'h123});
    tick();
    if0.i_trig = '0;
    check("t1_valid_after_capture", DW'(if0.o_valid), '0);
    check("t1_busy_after_capture", DW'(if0.o_busy), DW'(1));
    tick();
    check("t1_valid_after_grant", DW'(if0.o_valid), DW'(1));
    check("t1_data_after_grant", if0.o_data, {4'd2, 60'h123});
    tick();
    check("t1_valid_after_accept", DW'(if0.o_valid), '0);
    check("t1_busy_idle", DW'(if0.o_busy), '0);

    // 2: simultaneous events, fixed priority, back-to-back frames
    set_pl0(0, 60'hA0); set_pl0(2, 60'hA2); set_pl0(6, 60'hA6);
    if0.i_trig = 7'b1000101;
    exp_q0.push_back({4'd1, 60'hA0});
    exp_q0.push_back({4'd3, 60'hA2});
    exp_q0.push_back({4'd7, 60'hA6});
    tick();
    if0.i_trig = '0;
    repeat (4) tick();
    check("t2_drained_in_3_cycles", DW'(exp_q0.size()), '0);
    check("t2_valid_idle", DW'(if0.o_valid), '0);
    check("t2_no_overflow", DW'(if0.o_overflow), '0);

    // 3: round robin on the mode-1 instance, channels 0 and 2 retrigger each cycle
    foreach (rr_exp[j]) exp_q1.push_back(rr_exp[j]);
    for (int i = 1; i <= 8; i++) begin
      set_pl1(0, PW'(60'h100 + i));
      set_pl1(2, PW'(60'h100 + i));
      if1.i_trig = 7'b0000101;
      tick();
    end
    if1.i_trig = '0;
    repeat (3) tick();
    check("t3_rr_drained", DW'(exp_q1.size()), '0);
    check("t3_rr_overflow", DW'(if1.o_overflow), DW'(7'b0000101));
    check("t3_rr_busy_idle", DW'(if1.o_busy), '0);

    // 4: backpressure, overflow while stalled, clear versus same-cycle set
    set_pl0(5, 60'h555);
    if0.i_trig = 7'b0100000;
    exp_q0.push_back({4'd6, 60'h555});
    exp_q0.push_back({4'd5, 60'h4A});
    tick();
    if0.i_trig = '0;
    if0.i_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if0.i_trig = '0;
      if0.i_ovf_clr = 1'b0;
      if (i == 2) begin set_pl0(4, 60'h4A); if0.i_trig = 7'b0010000; end
      if (i == 5) begin set_pl0(4, 60'h4B); if0.i_trig = 7'b0010000; end
      if (i == 6) if0.i_ovf_clr = 1'b1;
      if (i == 7) begin set_pl0(4, 60'h4C); if0.i_trig = 7'b0010000; if0.i_ovf_clr = 1'b1; end
      tick();
      check("t4_stall_valid", DW'(if0.o_valid), DW'(1));
      check("t4_stall_data", if0.o_data, {4'd6, 60'h555});
      if (i == 5) check("t4_ovf_set", DW'(if0.o_overflow), DW'(7'b0010000));
      if (i == 6) check("t4_ovf_cleared", DW'(if0.o_overflow), '0);
      if (i == 7) check("t4_ovf_set_beats_clear", DW'(if0.o_overflow), DW'(7'b0010000));
    end
    if0.i_trig = '0;
    if0.i_ovf_clr = 1'b0;
    if0.i_ready = 1'b1;
    repeat (3) tick();
    check("t4_drained", DW'(exp_q0.size()), '0);
    check("t4_busy_idle", DW'(if0.o_busy), '0);
    check("t4_ovf_sticky", DW'(if0.o_overflow), DW'(7'b0010000));
    if0.i_ovf_clr = 1'b1;
    tick();
    if0.i_ovf_clr = 1'b0;
    check("t4_ovf_clear", DW'(if0.o_overflow), '0);

    // 5: retrigger in the cycle the slot is granted
    set_pl0(3, 60'h31);
    if0.i_trig = 7'b0001000;
    exp_q0.push_back({4'd4, 60'h31});
    exp_q0.push_back({4'd4, 60'h32});
    tick();
    set_pl0(3, 60'h32);
    tick();
    if0.i_trig = '0;
    repeat (3) tick();
    check("t5_drained", DW'(exp_q0.size()), '0);
    check("t5_no_overflow", DW'(if0.o_overflow), '0);
    check("t5_busy_idle", DW'(if0.o_busy), '0);

    // 6: asynchronous reset while a frame is held and three slots are pending
    if0.i_ready = 1'b0;
    set_pl0(0, 60'h60); set_pl0(1, 60'h61); set_pl0(2, 60'h62); set_pl0(3, 60'h63);
    if0.i_trig = 7'b0001111;
    tick();
    set_pl0(1, 60'h71);
    if0.i_trig = 7'b0000010;
    tick();
    if0.i_trig = '0;
    check("t6_pre_valid", DW'(if0.o_valid), DW'(1));
    check("t6_pre_data", if0.o_data, {4'd1, 60'h60});
    check("t6_pre_ovf", DW'(if0.o_overflow), DW'(7'b0000010));
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid0", DW'(if0.o_valid), '0);
    check("t6_rst_data0", if0.o_data, '0);
    check("t6_rst_ovf0", DW'(if0.o_overflow), '0);
    check("t6_rst_busy0", DW'(if0.o_busy), '0);
    check("t6_rst_ovf1", DW'(if1.o_overflow), '0);
    #4 rst = 1'b1;
    if0.i_ready = 1'b1;
    repeat (5) tick();
    check("t6_no_stale_valid", DW'(if0.o_valid), '0);
    check("t6_no_stale_busy", DW'(if0.o_busy), '0);
    set_pl1(0, 60'hC0); set_pl1(5, 60'hC5);
    if1.i_trig = 7'b0100001;
    exp_q1.push_back({4'd1, 60'hC0});
    exp_q1.push_back({4'd6, 60'hC5});
    tick();
    if1.i_trig = '0;
    repeat (3) tick();
    check("t6_rr_drained", DW'(exp_q1.size()), '0);

    // Final report
    check("final_q0_empty", DW'(exp_q0.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
